data_sram_arbiter: RTL and testbench

DATA_SRAM_ARBITER -- requirements
Module: data_sram_arbiter

---
 rtl/data_sram_arbiter.sv | 99 +++++++++
 tb/tb_data_sram_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_arbiter.sv
// Two-port arbiter in front of a single-cycle data SRAM. The pipeline port (p0) wins
// contention unless the auxiliary port (p1) has been denied STARVE_LIMIT cycles in a row.
module data_sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_req,
  input  logic [3:0]  p0_wen,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic [3:0]  p1_wen,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,

  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [1:0] rd_pend_q, rd_pend_d;  // {valid, port}
  logic       starved;

  always_comb begin
    starved = (starve_cnt_q == LIMIT);
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    if (!reset) begin
      if (p1_req && (!p0_req || starved)) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    if (p0_gnt) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = p0_wen;
      data_sram_addr  = p0_addr;
      data_sram_wdata = p0_wdata;
    end else if (p1_gnt) begin
      data_sram_en    = 1'b1;
      data_sram_wen   = p1_wen;
      data_sram_addr  = p1_addr;
      data_sram_wdata = p1_wdata;
    end
  end

  always_comb begin
    starve_cnt_d = 4'h0;
    if (p1_req && !p1_gnt) begin
      starve_cnt_d = (starve_cnt_q < LIMIT) ? starve_cnt_q + 4'h1 : starve_cnt_q;
    end

    rd_pend_d = 2'b00;
    if (data_sram_en && (data_sram_wen == 4'h0)) begin
      rd_pend_d = {1'b1, p1_gnt};
    end
  end

  // Gating with reset drops a read that was in flight when reset arrived.
  always_comb begin
    p0_rvalid = !reset && (rd_pend_q == 2'b10);
    p1_rvalid = !reset && (rd_pend_q == 2'b11);
    p0_rdata  = p0_rvalid ? data_sram_rdata : 32'h0;
    p1_rdata  = p1_rvalid ? data_sram_rdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 4'h0;
      rd_pend_q    <= 2'b00;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Bench for data_sram_arbiter: SRAM model, per-cycle reference model compare,
// and directed scenarios with literal expectations.
module tb_data_sram_arbiter;
  localparam int SL = 4;

  logic        clk, reset;
  logic        p0_req, p1_req, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [3:0]  p0_wen, p1_wen, data_sram_wen;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic        data_sram_en;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

  data_sram_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: read data one cycle after an enabled read, junk otherwise.
  always @(posedge clk) begin
    logic [31:0] a, cur;
    a = data_sram_addr;
    if (data_sram_en && data_sram_wen == 4'h0) begin
      data_sram_rdata = mem_rd(a);
    end else begin
      data_sram_rdata = $urandom;
      if (data_sram_en) begin
        cur = mem_rd(a);
        for (int b = 0; b < 4; b++)
          if (data_sram_wen[b]) cur[b*8 +: 8] = data_sram_wdata[b*8 +: 8];
        mem[a] = cur;
      end
    end
  end

  // Reference model: p1_wait counts consecutive denied p1 cycles, last_port is
  // the owner of the read issued in the previous cycle (-1 for none).
  int          m_wait = 0;
  int          m_last = -1;
  logic [31:0] m_last_data = 32'h0;

  initial begin
    logic e0, e1, een;
    logic [3:0] ewen;
    logic [31:0] eaddr, ewd;
    forever begin
      @(negedge clk);
      e1 = !reset && p1_req && (!p0_req || m_wait >= SL);
      e0 = !reset && p0_req && !e1;
      een   = e0 || e1;
      ewen  = e0 ? p0_wen   : e1 ? p1_wen   : 4'h0;
      eaddr = e0 ? p0_addr  : e1 ? p1_addr  : 32'h0;
      ewd   = e0 ? p0_wdata : e1 ? p1_wdata : 32'h0;
      chk("m_p0_gnt", p0_gnt, e0);
      chk("m_p1_gnt", p1_gnt, e1);
      chk("m_sram_en", data_sram_en, een);
      chk("m_sram_wen", data_sram_wen, ewen);
      chk("m_sram_addr", data_sram_addr, eaddr);
      chk("m_sram_wdata", data_sram_wdata, ewd);
      chk("m_p0_rvalid", p0_rvalid, !reset && m_last == 0);
      chk("m_p1_rvalid", p1_rvalid, !reset && m_last == 1);
      chk("m_p0_rdata", p0_rdata, (!reset && m_last == 0) ? m_last_data : 32'h0);
      chk("m_p1_rdata", p1_rdata, (!reset && m_last == 1) ? m_last_data : 32'h0);
      if (reset) begin
        m_wait = 0;
        m_last = -1;
      end else begin
        m_wait = (p1_req && !e1) ? m_wait + 1 : 0;
        if (een && ewen == 4'h0) begin
          m_last = e1 ? 1 : 0;
          m_last_data = mem_rd(eaddr);
        end else begin
          m_last = -1;
        end
      end
    end
  end

  task automatic set0(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    p0_req = r; p0_wen = w; p0_addr = a; p0_wdata = d;
  endtask
  task automatic set1(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    p1_req = r; p1_wen = w; p1_addr = a; p1_wdata = d;
  endtask
  task automatic idle();
    set0(0, 4'h0, 32'h0, 32'h0);
    set1(0, 4'h0, 32'h0, 32'h0);
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] gv;
    logic [8:0] sv;
    logic [31:0] alist [4];
    alist[0] = 32'h10; alist[1] = 32'h20; alist[2] = 32'h40; alist[3] = 32'h100;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h10]  = 32'h0000000A;
    mem[32'h20]  = 32'h0000000B;
    mem[32'h40]  = 32'hFFFF0000;
    data_sram_rdata = 32'h0;

    // Reset with requests pending: nothing may be issued.
    reset = 1'b1;
    set0(1, 4'h0, 32'h100, 32'h0);
    set1(1, 4'h0, 32'h20, 32'h0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rst_en", data_sram_en, 1'b0);
      nxt();
    end
    reset = 1'b0;
    idle();
    mid();
    chk("post_rst_p0_rvalid", p0_rvalid, 1'b0);
    chk("post_rst_p1_rvalid", p1_rvalid, 1'b0);
    nxt();

    // Single p0 read.
    set0(1, 4'h0, 32'h100, 32'h0);
    mid(); chk("rd_p0_gnt", p0_gnt, 1'b1); chk("rd_addr", data_sram_addr, 32'h100); nxt();
    idle();
    mid();
    chk("rd_p0_rvalid", p0_rvalid, 1'b1);
    chk("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd_p1_rvalid", p1_rvalid, 1'b0);
    nxt();

    // Alternating back-to-back reads.
    set0(1, 4'h0, 32'h10, 32'h0);
    mid(); chk("alt_p0_gnt", p0_gnt, 1'b1); nxt();
    set0(0, 4'h0, 32'h0, 32'h0);
    set1(1, 4'h0, 32'h20, 32'h0);
    mid(); chk("alt_p0_rvalid", p0_rvalid, 1'b1); chk("alt_p0_rdata", p0_rdata, 32'hA);
    chk("alt_p1_gnt", p1_gnt, 1'b1); nxt();
    idle();
    mid(); chk("alt_p1_rvalid", p1_rvalid, 1'b1); chk("alt_p1_rdata", p1_rdata, 32'hB);
    chk("alt_p0_rvalid2", p0_rvalid, 1'b0); nxt();

    // p1 byte write then read back through p0.
    set1(1, 4'h3, 32'h40, 32'h1234);
    mid(); chk("wr_en", data_sram_en, 1'b1); chk("wr_wen", data_sram_wen, 32'h3);
    chk("wr_addr", data_sram_addr, 32'h40); nxt();
    idle();
    set0(1, 4'h0, 32'h40, 32'h0);
    mid(); chk("wr_no_rvalid", p1_rvalid, 1'b0); nxt();
    idle();
    mid(); chk("wr_readback", p0_rdata, 32'hFFFF1234); nxt();

    // Sustained contention.
    for (int i = 0; i < 10; i++) begin
      set0(1, 4'h0, 32'h10, 32'h0);
      set1(1, 4'h0, 32'h20, 32'h0);
      mid(); gv[i] = p1_gnt; nxt();
    end
    chk("contend_pattern", 32'(gv), 32'h210);
    idle(); mid(); nxt();

    // Starvation count restarts after p1 drops its request.
    for (int i = 0; i < 9; i++) begin
      set0(1, 4'h1, 32'h40, 32'h55);
      set1(i != 3, 4'h0, 32'h20, 32'h0);
      mid(); sv[i] = p1_gnt; nxt();
    end
    chk("starve_restart", 32'(sv), 32'h100);
    idle(); mid(); nxt();

    // Random traffic, checked by the model only.
    for (int i = 0; i < 80; i++) begin
      reset = ($urandom_range(0, 19) == 0);
      set0(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           alist[$urandom_range(0, 3)], $urandom);
      set1(($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           alist[$urandom_range(0, 3)], $urandom);
      mid(); nxt();
    end
    reset = 1'b0;
    idle(); mid(); nxt();

    // Reset right after a granted read, with starve count built up.
    for (int i = 0; i < 2; i++) begin
      set0(1, 4'hF, 32'h10, 32'h77);
      set1(1, 4'h0, 32'h20, 32'h0);
      mid(); nxt();
    end
    set0(1, 4'h0, 32'h100, 32'h0);
    mid(); chk("rr_p0_gnt", p0_gnt, 1'b1); nxt();
    reset = 1'b1;
    mid(); chk("rr_rvalid_n1", p0_rvalid, 1'b0); chk("rr_en_n1", data_sram_en, 1'b0); nxt();
    reset = 1'b0;
    mid(); chk("rr_rvalid_n2", p0_rvalid, 1'b0);
    chk("rr_starve_cnt", 32'(dut.starve_cnt_q), 32'h0); nxt();
    idle(); mid(); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
